// File: rtl/fu_pkg.sv
// Shared constants and the holding-slot entry type for the functional-unit
// write-back arbiter.
package fu_pkg;

    localparam int XLEN     = 32;
    localparam int NUM_SRC  = 5;
    localparam int IDX_ALU  = 0;
    localparam int IDX_MEM  = 1;
    localparam int IDX_MUL  = 2;
    localparam int IDX_DIV  = 3;
    localparam int IDX_JUMP = 4;

    typedef struct packed {
        logic            valid;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
        logic            taken;
        logic [XLEN-1:0] pc;
    } slot_t;

endpackage

// File: rtl/wb_slot.sv
// Single-entry holding slot for one functional-unit result. A finish pulse
// that arrives while the slot is occupied is dropped and flagged on ovf_o.
module wb_slot
    import fu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            fin_i,
    input  logic            grant_i,
    input  logic [4:0]      rd_i,
    input  logic [XLEN-1:0] data_i,
    input  logic            taken_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            valid_o,
    output logic [4:0]      rd_o,
    output logic [XLEN-1:0] data_o,
    output logic            taken_o,
    output logic [XLEN-1:0] pc_o,
    output logic            ovf_o
);

    slot_t entry_q;
    slot_t entry_d;

    // Next entry: a grant always empties the slot; capture only into an empty slot.
    always_comb begin
        entry_d = entry_q;
        if (grant_i) begin
            entry_d.valid = 1'b0;
        end else if (fin_i && !entry_q.valid) begin
            entry_d.valid = 1'b1;
            entry_d.rd    = rd_i;
            entry_d.data  = data_i;
            entry_d.taken = taken_i;
            entry_d.pc    = pc_i;
        end else begin
            entry_d = entry_q;
        end
    end

    // Slot storage register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign valid_o = entry_q.valid;
    assign rd_o    = entry_q.rd;
    assign data_o  = entry_q.data;
    assign taken_o = entry_q.taken;
    assign pc_o    = entry_q.pc;
    assign ovf_o   = fin_i & entry_q.valid;

endmodule

// File: rtl/fu_wb_arbiter.sv
// Write-back arbiter: one holding slot per functional unit, one registered
// write-back per cycle. Define WB_ROUND_ROBIN_EN for round-robin arbitration.
module fu_wb_arbiter #(
    parameter int XLEN     = fu_pkg::XLEN,
    parameter int NUM_SRC  = fu_pkg::NUM_SRC,
    parameter int JUMP_IDX = fu_pkg::IDX_JUMP
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_SRC-1:0]      fin_i,
    input  logic [5*NUM_SRC-1:0]    rd_i,
    input  logic [XLEN*NUM_SRC-1:0] data_i,
    input  logic                    jmp_taken_i,
    input  logic [XLEN-1:0]         jmp_pc_i,
    output logic [NUM_SRC-1:0]      hold_o,
    output logic                    wb_en,
    output logic [4:0]              wb_rd,
    output logic [XLEN-1:0]         wb_data,
    output logic [2:0]              wb_src,
    output logic                    redirect_valid,
    output logic [XLEN-1:0]         redirect_pc,
    output logic                    overflow_err
);
    import fu_pkg::slot_t;

    slot_t              slot_s [NUM_SRC];
    logic [NUM_SRC-1:0] valid_s;
    logic [NUM_SRC-1:0] ovf_s;
    logic [NUM_SRC-1:0] gnt_vec_s;
    logic               gnt_any_s;
    logic [2:0]         gnt_idx_s;
    slot_t              gnt_entry_s;

    logic               wb_en_q, wb_en_d;
    logic [4:0]         wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]    wb_data_q, wb_data_d;
    logic [2:0]         wb_src_q, wb_src_d;
    logic               rv_q, rv_d;
    logic [XLEN-1:0]    rpc_q, rpc_d;
    logic               ovf_q, ovf_d;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_slot
        wb_slot u_slot (
            .clk     (clk),
            .rst     (rst),
            .fin_i   (fin_i[k]),
            .grant_i (gnt_vec_s[k]),
            .rd_i    (rd_i[5*k +: 5]),
            .data_i  (data_i[XLEN*k +: XLEN]),
            .taken_i ((k == JUMP_IDX) ? jmp_taken_i : 1'b0),
            .pc_i    ((k == JUMP_IDX) ? jmp_pc_i : {XLEN{1'b0}}),
            .valid_o (slot_s[k].valid),
            .rd_o    (slot_s[k].rd),
            .data_o  (slot_s[k].data),
            .taken_o (slot_s[k].taken),
            .pc_o    (slot_s[k].pc),
            .ovf_o   (ovf_s[k])
        );
        assign valid_s[k] = slot_s[k].valid;
    end

`ifdef WB_ROUND_ROBIN_EN
    logic [2:0]           rr_q;
    logic [2*NUM_SRC-1:0] dbl_s;
    logic [NUM_SRC-1:0]   rot_s;
    logic [NUM_SRC-1:0]   rot_low_s;
    logic [2:0]           off_s;
    logic [3:0]           sum_s;

    // Rotate the request vector so the search starts just after the last grant.
    always_comb begin
        dbl_s     = {valid_s, valid_s} >> (rr_q + 3'd1);
        rot_s     = dbl_s[NUM_SRC-1:0];
        rot_low_s = rot_s & (~rot_s + {{(NUM_SRC-1){1'b0}}, 1'b1});
        off_s     = 3'd0;
        for (int k = 0; k < NUM_SRC; k++) begin
            off_s = off_s | ({3{rot_low_s[k]}} & 3'(k));
        end
        sum_s     = {1'b0, rr_q} + 4'd1 + {1'b0, off_s};
        gnt_any_s = |valid_s;
        if (sum_s >= 4'(NUM_SRC)) begin
            gnt_idx_s = 3'(sum_s - 4'(NUM_SRC));
        end else begin
            gnt_idx_s = sum_s[2:0];
        end
    end

    // Round-robin pointer remembers the most recent grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q <= 3'd0;
        end else if (gnt_any_s) begin
            rr_q <= gnt_idx_s;
        end else begin
            rr_q <= rr_q;
        end
    end
`else
    logic [NUM_SRC-1:0] low_s;

    // Fixed priority: the redirect source first, then the lowest index.
    always_comb begin
        low_s     = valid_s & (~valid_s + {{(NUM_SRC-1){1'b0}}, 1'b1});
        gnt_any_s = |valid_s;
        gnt_idx_s = 3'd0;
        if (valid_s[JUMP_IDX]) begin
            gnt_idx_s = 3'(JUMP_IDX);
        end else begin
            for (int k = 0; k < NUM_SRC; k++) begin
                gnt_idx_s = gnt_idx_s | ({3{low_s[k]}} & 3'(k));
            end
        end
    end
`endif

    // One-hot grant and the selected slot contents.
    always_comb begin
        gnt_vec_s   = gnt_any_s ? (NUM_SRC'(1) << gnt_idx_s) : {NUM_SRC{1'b0}};
        gnt_entry_s = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            gnt_entry_s = gnt_entry_s | ({$bits(slot_t){gnt_vec_s[k]}} & slot_s[k]);
        end
    end

    // Write-back next state; address, data and source hold when nothing is granted.
    always_comb begin
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        wb_src_d  = wb_src_q;
        ovf_d     = ovf_q | (|ovf_s);
        if (gnt_any_s) begin
            wb_en_d   = (gnt_entry_s.rd != 5'd0);
            wb_rd_d   = gnt_entry_s.rd;
            wb_data_d = gnt_entry_s.data;
            wb_src_d  = gnt_idx_s;
            rv_d      = (gnt_idx_s == 3'(JUMP_IDX)) && gnt_entry_s.taken;
        end else begin
            wb_en_d   = 1'b0;
            rv_d      = 1'b0;
        end
        if (rv_d) begin
            rpc_d = gnt_entry_s.pc;
        end else begin
            rpc_d = rpc_q;
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_en_q   <= 1'b0;
            wb_rd_q   <= 5'd0;
            wb_data_q <= {XLEN{1'b0}};
            wb_src_q  <= 3'd0;
            rv_q      <= 1'b0;
            rpc_q     <= {XLEN{1'b0}};
            ovf_q     <= 1'b0;
        end else begin
            wb_en_q   <= wb_en_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
            wb_src_q  <= wb_src_d;
            rv_q      <= rv_d;
            rpc_q     <= rpc_d;
            ovf_q     <= ovf_d;
        end
    end

    assign hold_o         = valid_s;
    assign wb_en          = wb_en_q;
    assign wb_rd          = wb_rd_q;
    assign wb_data        = wb_data_q;
    assign wb_src         = wb_src_q;
    assign redirect_valid = rv_q;
    assign redirect_pc    = rpc_q;
    assign overflow_err   = ovf_q;

endmodule

// File: tb/tb_fu_wb_arbiter.sv
// Self-checking bench for fu_wb_arbiter: transaction-level model compared every
// cycle, plus hand-computed expectations for the key scenarios.
module tb_fu_wb_arbiter;

    localparam int XL = 32;
    localparam int NS = 5;
    localparam int JI = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [NS-1:0]   fin;
    logic [5*NS-1:0] rd_v;
    logic [XL*NS-1:0] data_v;
    logic            taken;
    logic [XL-1:0]   pc;
    logic [NS-1:0]   hold_o;
    logic            wb_en;
    logic [4:0]      wb_rd;
    logic [XL-1:0]   wb_data;
    logic [2:0]      wb_src;
    logic            redirect_valid;
    logic [XL-1:0]   redirect_pc;
    logic            overflow_err;

    fu_wb_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .fin_i          (fin),
        .rd_i           (rd_v),
        .data_i         (data_v),
        .jmp_taken_i    (taken),
        .jmp_pc_i       (pc),
        .hold_o         (hold_o),
        .wb_en          (wb_en),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .wb_src         (wb_src),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .overflow_err   (overflow_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    // Model state: pending results per source.
    bit          m_valid [NS];
    logic [4:0]  m_rd    [NS];
    logic [31:0] m_data  [NS];
    bit          m_taken [NS];
    logic [31:0] m_pc    [NS];
    int          m_last;
    // Expected outputs after the next clock edge.
    logic [NS-1:0] e_hold;
    logic          e_en, e_rv, e_ovf;
    logic [4:0]    e_rd;
    logic [31:0]   e_data, e_pc;
    logic [2:0]    e_src;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NS; k++) begin
            m_valid[k] = 0; m_rd[k] = '0; m_data[k] = '0; m_taken[k] = 0; m_pc[k] = '0;
        end
        m_last = 0;
        e_hold = '0; e_en = 0; e_rv = 0; e_ovf = 0; e_rd = '0; e_data = '0; e_pc = '0; e_src = '0;
    endtask

    // Advance the model across one clock edge using the currently driven inputs.
    task automatic model_step();
        int g;
        g = -1;
`ifdef WB_ROUND_ROBIN_EN
        for (int i = 1; i <= NS; i++) begin
            if (g < 0 && m_valid[(m_last + i) % NS]) g = (m_last + i) % NS;
        end
`else
        if (m_valid[JI]) g = JI;
        for (int i = 0; i < NS; i++) begin
            if (g < 0 && m_valid[i]) g = i;
        end
`endif
        e_en = 0;
        e_rv = 0;
        if (g >= 0) begin
            e_en   = (m_rd[g] != 0);
            e_rd   = m_rd[g];
            e_data = m_data[g];
            e_src  = 3'(g);
            e_rv   = (g == JI) && m_taken[g];
            if (e_rv) e_pc = m_pc[g];
            m_last = g;
        end
        for (int k = 0; k < NS; k++) begin
            if (fin[k] && m_valid[k]) e_ovf = 1;
            if (g == k) begin
                m_valid[k] = 0;
            end else if (fin[k] && !m_valid[k]) begin
                m_valid[k] = 1;
                m_rd[k]    = rd_v[5*k +: 5];
                m_data[k]  = data_v[XL*k +: XL];
                m_taken[k] = (k == JI) ? taken : 1'b0;
                m_pc[k]    = (k == JI) ? pc : '0;
            end
        end
        for (int k = 0; k < NS; k++) e_hold[k] = m_valid[k];
    endtask

    task automatic set_src(input int k, input logic [4:0] r, input logic [31:0] d);
        rd_v[5*k +: 5]    = r;
        data_v[XL*k +: XL] = d;
    endtask

    task automatic tick(input logic [NS-1:0] f);
        fin = f;
        model_step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("hold_o", 64'(hold_o), 64'(e_hold));
            chk("wb_en", 64'(wb_en), 64'(e_en));
            chk("wb_rd", 64'(wb_rd), 64'(e_rd));
            chk("wb_data", 64'(wb_data), 64'(e_data));
            chk("wb_src", 64'(wb_src), 64'(e_src));
            chk("redirect_valid", 64'(redirect_valid), 64'(e_rv));
            chk("redirect_pc", 64'(redirect_pc), 64'(e_pc));
            chk("overflow_err", 64'(overflow_err), 64'(e_ovf));
        end
    end

    logic [2:0] seq [5];

    initial begin
        rst = 1'b1; fin = '0; rd_v = '0; data_v = '0; taken = 1'b0; pc = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_hold", 64'(hold_o), 64'h0);
        chk("rst_wb_en", 64'(wb_en), 64'h0);
        chk("rst_wb_data", 64'(wb_data), 64'h0);
        chk("rst_redirect", 64'(redirect_valid), 64'h0);
        rst = 1'b0;
        chk_en = 1'b1;
        #1;

        // Basic ALU write-back with one cycle of latency.
        set_src(0, 5'd5, 32'h1234);
        tick(5'b00001);
        chk("alu_hold", 64'(hold_o), 64'h01);
        chk("alu_no_bypass", 64'(wb_en), 64'h0);
        tick(5'b00000);
        chk("alu_wb_en", 64'(wb_en), 64'h1);
        chk("alu_wb_rd", 64'(wb_rd), 64'h5);
        chk("alu_wb_data", 64'(wb_data), 64'h1234);
        chk("alu_wb_src", 64'(wb_src), 64'h0);
        chk("alu_hold_clr", 64'(hold_o), 64'h0);
        tick(5'b00000);
        chk("idle_wb_en", 64'(wb_en), 64'h0);
        chk("idle_wb_rd_hold", 64'(wb_rd), 64'h5);

        // Taken jump then not-taken jump.
        set_src(4, 5'd1, 32'h44); taken = 1'b1; pc = 32'h80;
        tick(5'b10000);
        tick(5'b00000);
        chk("jmp_rv", 64'(redirect_valid), 64'h1);
        chk("jmp_pc", 64'(redirect_pc), 64'h80);
        chk("jmp_wb_data", 64'(wb_data), 64'h44);
        chk("jmp_wb_src", 64'(wb_src), 64'h4);
        tick(5'b00000);
        chk("jmp_rv_pulse", 64'(redirect_valid), 64'h0);
        set_src(4, 5'd1, 32'h55); taken = 1'b0; pc = 32'h90;
        tick(5'b10000);
        tick(5'b00000);
        chk("nt_rv", 64'(redirect_valid), 64'h0);
        chk("nt_wb_en", 64'(wb_en), 64'h1);

        // All five sources at once.
        for (int k = 0; k < NS; k++) set_src(k, 5'(k + 1), 32'h100 + 32'(k));
        taken = 1'b1; pc = 32'h200;
        tick(5'b11111);
        chk("all_hold", 64'(hold_o), 64'h1f);
        seq[0] = 3'd4; seq[1] = 3'd0; seq[2] = 3'd1; seq[3] = 3'd2; seq[4] = 3'd3;
        for (int i = 0; i < NS; i++) begin
            tick(5'b00000);
`ifndef WB_ROUND_ROBIN_EN
            chk("all_order", 64'(wb_src), 64'(seq[i]));
`endif
        end
        chk("all_drained", 64'(hold_o), 64'h0);

        // Branch with rd = 0: no register write but redirect still issued.
        set_src(4, 5'd0, 32'h99); taken = 1'b1; pc = 32'h300;
        tick(5'b10000);
        tick(5'b00000);
        chk("rd0_wb_en", 64'(wb_en), 64'h0);
        chk("rd0_rv", 64'(redirect_valid), 64'h1);
        chk("rd0_pc", 64'(redirect_pc), 64'h300);
        chk("rd0_drained", 64'(hold_o), 64'h0);

        // Re-capture the cycle after a grant is legal.
        set_src(2, 5'd6, 32'hC0);
        tick(5'b00100);
        tick(5'b00000);
        set_src(2, 5'd6, 32'hD0);
        tick(5'b00100);
        chk("recap_no_ovf", 64'(overflow_err), 64'h0);
        chk("recap_hold", 64'(hold_o), 64'h04);
        tick(5'b00000);
        chk("recap_data", 64'(wb_data), 64'hD0);

        // Overflow: second finish while slot 2 still full.
        set_src(2, 5'd7, 32'hAAA);
        tick(5'b00100);
        set_src(2, 5'd8, 32'hBBB);
        tick(5'b00100);
        chk("ovf_flag", 64'(overflow_err), 64'h1);
        chk("ovf_orig_data", 64'(wb_data), 64'hAAA);
        tick(5'b00000);
        chk("ovf_dropped", 64'(wb_en), 64'h0);

        // Asynchronous reset in the middle of a drain.
        for (int k = 0; k < NS; k++) set_src(k, 5'(k + 10), 32'h500 + 32'(k));
        tick(5'b11111);
        tick(5'b00000);
        #1 rst = 1'b1;
        model_reset();
        #1;
        chk("mrst_hold", 64'(hold_o), 64'h0);
        chk("mrst_wb_en", 64'(wb_en), 64'h0);
        chk("mrst_wb_rd", 64'(wb_rd), 64'h0);
        chk("mrst_wb_data", 64'(wb_data), 64'h0);
        chk("mrst_wb_src", 64'(wb_src), 64'h0);
        chk("mrst_rpc", 64'(redirect_pc), 64'h0);
        chk("mrst_ovf", 64'(overflow_err), 64'h0);
        fin = '0;
        @(negedge clk);
        rst = 1'b0;
        #1;

        // Random legal traffic respecting hold_o.
        for (int c = 0; c < 60; c++) begin
            for (int k = 0; k < NS; k++) set_src(k, 5'($urandom_range(0, 31)), $urandom);
            taken = 1'($urandom_range(0, 1));
            pc = $urandom;
            tick(5'($urandom_range(0, 31)) & ~e_hold);
        end
        repeat (6) tick(5'b00000);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
